// File: rtl/div_issue_ctrl.sv
// Execute-stage issue controller for the sequential divider: launches one divide at a time,
// stalls the pipeline while it is in flight, and writes back the quotient, all-ones or a forced timeout value.
module div_issue_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned RD_BITS = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [RD_BITS-1:0] op_rd,
    output logic               stall,
    output logic               div_start,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    input  logic               div_done,
    input  logic [WIDTH-1:0]   div_result,
    output logic               wb_valid,
    output logic [RD_BITS-1:0] wb_rd,
    output logic [WIDTH-1:0]   wb_data,
    output logic               err_timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic            accept;
    logic            b_zero;
    logic            timeout_hit;

    logic            op_ready_d;
    logic            stall_d;
    logic            div_start_d;
    logic            wb_valid_d;
    logic            err_timeout_d;

    assign accept      = (state_q == S_IDLE) && op_valid;
    assign b_zero      = (op_b == '0);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a divider completion takes priority over the watchdog
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    state_d = b_zero ? S_WB : S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (div_done || timeout_hit) begin
                    state_d = S_WB;
                end
            end
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every control output leaves a flop
    always_comb begin
        op_ready_d    = (state_d == S_IDLE);
        stall_d       = (state_d != S_IDLE);
        div_start_d   = (state_d == S_LAUNCH);
        wb_valid_d    = (state_d == S_WB);
        err_timeout_d = 1'b0;
        if (state_q == S_WAIT && !div_done && timeout_hit) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_ready    <= 1'b1;
            stall       <= 1'b0;
            div_start   <= 1'b0;
            wb_valid    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            op_ready    <= op_ready_d;
            stall       <= stall_d;
            div_start   <= div_start_d;
            wb_valid    <= wb_valid_d;
            err_timeout <= err_timeout_d;
        end
    end

    // Operand/result latches and watchdog counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_a   <= '0;
            div_b   <= '0;
            wb_rd   <= '0;
            wb_data <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                div_a <= op_a;
                div_b <= op_b;
                wb_rd <= op_rd;
                if (b_zero) begin
                    wb_data <= '1;
                end
            end
            case (state_q)
                S_LAUNCH: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (div_done) begin
                        wb_data <= div_result;
                    end else if (timeout_hit) begin
                        wb_data <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: inputs change and outputs are sampled on the falling clock edge.
module tb_div_issue_ctrl;

    logic       clk;
    logic       reset;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] op_rd;
    logic       stall;
    logic       div_start;
    logic [7:0] div_a;
    logic [7:0] div_b;
    logic       div_done;
    logic [7:0] div_result;
    logic       wb_valid;
    logic [3:0] wb_rd;
    logic [7:0] wb_data;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;

    div_issue_ctrl #(.WIDTH(8), .RD_BITS(4), .TIMEOUT(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_rd      (op_rd),
        .stall      (stall),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_result (div_result),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %0b exp 1", op_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got %0b exp 0", div_start); end
        checks++; if ({div_a, div_b} !== 16'h0) begin errors++; $display("FAIL reset_div_ab got %0h exp 0", {div_a, div_b}); end
        checks++; if ({wb_valid, wb_rd, wb_data, err_timeout} !== 14'h0) begin
            errors++; $display("FAIL reset_wb got %0h exp 0", {wb_valid, wb_rd, wb_data, err_timeout}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        op_valid = 1'b1; op_a = 8'd16; op_b = 8'd4; op_rd = 4'd3;
        tick();
        checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL basic_start got %0b exp 1", div_start); end
        checks++; if (stall !== 1'b1 || op_ready !== 1'b0) begin errors++; $display("FAIL basic_stall got %0b/%0b exp 1/0", stall, op_ready); end
        checks++; if (div_a !== 8'd16 || div_b !== 8'd4) begin errors++; $display("FAIL basic_operands got %0d/%0d exp 16/4", div_a, div_b); end
        op_valid = 1'b0; op_a = 8'd0; op_b = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (div_start !== 1'b0 || div_a !== 8'd16 || div_b !== 8'd4 || stall !== 1'b1) begin
                errors++; $display("FAIL basic_hold got start=%0b a=%0d b=%0d stall=%0b exp 0/16/4/1", div_start, div_a, div_b, stall); end
        end
        div_done = 1'b1; div_result = 8'd4;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL basic_early_wb got %0b exp 0", wb_valid); end
        tick();
        div_done = 1'b0; div_result = 8'd0;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd3 || wb_data !== 8'd4 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL basic_wb got v=%0b rd=%0d d=%0d e=%0b exp 1/3/4/0", wb_valid, wb_rd, wb_data, err_timeout); end
        tick();
        checks++; if (wb_valid !== 1'b0 || op_ready !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL basic_idle got v=%0b rdy=%0b st=%0b exp 0/1/0", wb_valid, op_ready, stall); end
    endtask

    task automatic test_back_to_back();
        op_valid = 1'b1; op_a = 8'd10; op_b = 8'd2; op_rd = 4'd1;
        tick();
        checks++; if (div_start !== 1'b1 || div_a !== 8'd10) begin errors++; $display("FAIL b2b_launch1 got %0b/%0d exp 1/10", div_start, div_a); end
        op_a = 8'd15; op_b = 8'd3; op_rd = 4'd2;
        tick();
        checks++; if (div_a !== 8'd10 || div_b !== 8'd2 || op_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_hold1 got a=%0d b=%0d rdy=%0b exp 10/2/0", div_a, div_b, op_ready); end
        tick();
        div_done = 1'b1; div_result = 8'd5;
        tick();
        div_done = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd1 || wb_data !== 8'd5 || stall !== 1'b1) begin
            errors++; $display("FAIL b2b_wb1 got v=%0b rd=%0d d=%0d st=%0b exp 1/1/5/1", wb_valid, wb_rd, wb_data, stall); end
        tick();
        checks++; if (op_ready !== 1'b1 || wb_valid !== 1'b0 || div_start !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got rdy=%0b v=%0b s=%0b exp 1/0/0", op_ready, wb_valid, div_start); end
        tick();
        checks++; if (div_start !== 1'b1 || div_a !== 8'd15 || div_b !== 8'd3) begin
            errors++; $display("FAIL b2b_launch2 got s=%0b a=%0d b=%0d exp 1/15/3", div_start, div_a, div_b); end
        op_valid = 1'b0;
        tick();
        tick();
        div_done = 1'b1; div_result = 8'd5;
        tick();
        div_done = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd2 || wb_data !== 8'd5) begin
            errors++; $display("FAIL b2b_wb2 got v=%0b rd=%0d d=%0d exp 1/2/5", wb_valid, wb_rd, wb_data); end
        tick();
        checks++; if (wb_valid !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL b2b_end got v=%0b rdy=%0b exp 0/1", wb_valid, op_ready); end
    endtask

    task automatic test_div_zero();
        op_valid = 1'b1; op_a = 8'd7; op_b = 8'd0; op_rd = 4'd5;
        tick();
        op_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd5 || wb_data !== 8'hFF || err_timeout !== 1'b0) begin
            errors++; $display("FAIL dz_wb got v=%0b rd=%0d d=%0h e=%0b exp 1/5/ff/0", wb_valid, wb_rd, wb_data, err_timeout); end
        checks++; if (div_start !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL dz_start got s=%0b st=%0b exp 0/1", div_start, stall); end
        tick();
        checks++; if (div_start !== 1'b0 || wb_valid !== 1'b0 || op_ready !== 1'b1) begin
            errors++; $display("FAIL dz_idle got s=%0b v=%0b rdy=%0b exp 0/0/1", div_start, wb_valid, op_ready); end
    endtask

    task automatic test_timeout();
        int  waits;
        bit  seen;
        op_valid = 1'b1; op_a = 8'd50; op_b = 8'd7; op_rd = 4'd6;
        tick();
        op_valid = 1'b0;
        waits = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (wb_valid === 1'b1) seen = 1'b1;
            else waits++;
        end
        checks++; if (!seen || waits != 32) begin errors++; $display("FAIL to_wait_cycles got seen=%0b waits=%0d exp 1/32", seen, waits); end
        checks++; if (wb_data !== 8'hFF || err_timeout !== 1'b1 || wb_rd !== 4'd6) begin
            errors++; $display("FAIL to_wb got d=%0h e=%0b rd=%0d exp ff/1/6", wb_data, err_timeout, wb_rd); end
        tick();
        checks++; if (err_timeout !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL to_idle got e=%0b rdy=%0b exp 0/1", err_timeout, op_ready); end
        tick();
        tick();
        div_done = 1'b1; div_result = 8'h11;
        tick();
        div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL to_late_done got v=%0b st=%0b exp 0/0", wb_valid, stall); end
            tick();
        end
    endtask

    task automatic test_done_at_timeout();
        op_valid = 1'b1; op_a = 8'd80; op_b = 8'd2; op_rd = 4'd7;
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        checks++; if (wb_valid !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL race_last_wait got v=%0b st=%0b exp 0/1", wb_valid, stall); end
        div_done = 1'b1; div_result = 8'h2A;
        tick();
        div_done = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 8'h2A || err_timeout !== 1'b0 || wb_rd !== 4'd7) begin
            errors++; $display("FAIL race_wb got v=%0b d=%0h e=%0b rd=%0d exp 1/2a/0/7", wb_valid, wb_data, err_timeout, wb_rd); end
        tick();
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op_a = 8'd100; op_b = 8'd9; op_rd = 4'd4;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || op_ready !== 1'b1 || div_a !== 8'd0 || div_b !== 8'd0 || wb_rd !== 4'd0) begin
            errors++; $display("FAIL rst_mid_async got st=%0b rdy=%0b a=%0d b=%0d rd=%0d exp 0/1/0/0/0", stall, op_ready, div_a, div_b, wb_rd); end
        tick();
        reset = 1'b1;
        tick();
        div_done = 1'b1; div_result = 8'd11;
        tick();
        div_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (wb_valid !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_stray got v=%0b rdy=%0b exp 0/1", wb_valid, op_ready); end
            tick();
        end
        op_valid = 1'b1; op_a = 8'd9; op_b = 8'd3; op_rd = 4'd8;
        tick();
        op_valid = 1'b0;
        checks++; if (div_start !== 1'b1 || div_a !== 8'd9 || div_b !== 8'd3) begin
            errors++; $display("FAIL rst_mid_launch got s=%0b a=%0d b=%0d exp 1/9/3", div_start, div_a, div_b); end
        tick();
        div_done = 1'b1; div_result = 8'd3;
        tick();
        div_done = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 8'd3 || wb_rd !== 4'd8 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_mid_wb got v=%0b d=%0d rd=%0d e=%0b exp 1/3/8/0", wb_valid, wb_data, wb_rd, err_timeout); end
        tick();
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_a = 8'd0; op_b = 8'd0; op_rd = 4'd0;
        div_done = 1'b0; div_result = 8'd0;
        #1 reset = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Execute-stage controller directly upstream of the sequential restoring divider. Accepts one decoded divide operation at a time, launches the divider with a start pulse and stable operands, waits for its done pulse, and returns the quotient to register writeback. It also stalls the pipeline while the divide is in flight. Divide-by-zero is resolved locally, and a watchdog bounds the wait on a divider that never finishes.

## Interface
- WIDTH, 8, operand/result width (matches divider)
- RD_BITS, 4, destination register index width
- TIMEOUT, 32, max cycles spent in WAIT before forced completion (≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low = reset asserted
- op_valid  in  1  decoded divide op present
- op_ready  out  1  controller can accept an op (IDLE)
- op_a  in  WIDTH  dividend
- op_b  in  WIDTH  divisor
- op_rd  in  RD_BITS  destination register
- stall  out  1  pipeline hold; high whenever state ≠ IDLE
- div_start  out  1  one-cycle launch pulse to divider
- div_a  out  WIDTH  dividend to divider, held from LAUNCH through WAIT
- div_b  out  WIDTH  divisor to divider, held from LAUNCH through WAIT
- div_done  in  1  divider completion pulse; div_result valid that cycle
- div_result  in  WIDTH  quotient from divider
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  RD_BITS  writeback register
- wb_data  out  WIDTH  writeback value
- err_timeout  out  1  high with wb_valid when the write was forced by the watchdog

## Operation
- States: IDLE, LAUNCH, WAIT, WB. All outputs are decoded from registered state and latches. There is no input-to-output combinational path.
- IDLE
  - op_ready=1, stall=0.
  - On op_valid at a rising edge: latch op_a, op_b and op_rd.
  - If op_b==0: latch wb_data = all-ones, go to WB. The divider is never started.
  - Otherwise go to LAUNCH.
- LAUNCH
  - div_start=1 for exactly this cycle. div_a/div_b come from the latches.
  - Watchdog counter cleared to 0. Next state WAIT.
- WAIT
  - div_start=0. div_a/div_b stay unchanged.
  - Counter increments each cycle.
  - div_done=1: latch div_result into wb_data, go to WB, err flag 0.
  - Otherwise, if the counter equals TIMEOUT-1: latch wb_data = all-ones, set err flag, go to WB.
  - If div_done and the timeout occur in the same cycle, div_done wins: result is taken, err=0.
- WB
  - wb_valid=1 for exactly one cycle. wb_rd = latched rd. err_timeout = err flag.
  - Next state IDLE.
- div_done outside WAIT is ignored; this includes late pulses after a timeout.
- op_valid while op_ready=0 is not accepted. The upstream holds the op under stall.
- Widths: no arithmetic beyond the counter. The counter is sized ceil(log2(TIMEOUT))+1 bits and never wraps.

## Timing
- Reset values (reset low, immediate): state IDLE, op_ready=1, stall=0, div_start=0, div_a=div_b=0, wb_valid=0, wb_rd=0, wb_data=0, err_timeout=0, counter=0.
- Acceptance: op_valid·op_ready sampled at edge k.
  - Cycle after k: LAUNCH, div_start=1, stall=1.
  - Next cycle: WAIT.
- Divider done in cycle d: wb_valid in cycle d+1. The next op can be accepted at the end of cycle d+2 (IDLE).
- Divide-by-zero accepted at edge k: wb_valid in cycle k+1, IDLE in k+2.
- Timeout: WAIT lasts TIMEOUT cycles, then WB.
- Back-to-back: minimum spacing between acceptances is 4 cycles plus the divider latency.
- Reset asserted mid-operation: the in-flight op is dropped with no wb_valid. Outputs go to reset values asynchronously. Any subsequent div_done is ignored.

## Test plan
- Reset low for 2 cycles, then op 16/4 rd=3 → div_start one cycle after accept, div_a=16, div_b=4 held. Divider done returns 4 → wb_valid one cycle, wb_rd=3, wb_data=4, err_timeout=0.
- Sequential ops 10/2 rd=1 then 15/3 rd=2 with op_valid held high → second op accepted only after IDLE. Writebacks are 5 then 5, each wb_valid exactly one cycle, stall high between acceptance and WB.
- Op 7/0 rd=5 → div_start never asserted, wb_valid the cycle after accept with wb_data=8'hFF, err_timeout=0.
- Divider model never asserts done, TIMEOUT=32 → exactly 32 WAIT cycles, then wb_valid with wb_data=8'hFF, err_timeout=1. A div_done injected 3 cycles later causes no writeback.
- div_done asserted with div_result=8'h2A in the final WAIT cycle (counter=TIMEOUT-1) → wb_data=8'h2A, err_timeout=0.
- Reset pulled low during WAIT of 100/9, then released, then div_done pulsed → no wb_valid, op_ready=1. A new op 9/3 then completes with wb_data=3.
